// File: rtl/median_out_stage.sv
// Output stage of the median systolic array: tracks window fill, selects the
// median cell's R1 and holds it in a valid/ready register with overrun detection.
module median_out_stage #(
  parameter int DATA_LENGTH = 32,
  parameter int WMAX        = 16,
  parameter int LOG_WMAX    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [LOG_WMAX-1:0]         W,
  input  logic [WMAX*DATA_LENGTH-1:0] R1_bus,
  input  logic                        out_ready,
  output logic [DATA_LENGTH-1:0]      median,
  output logic                        median_valid,
  output logic [LOG_WMAX-1:0]         fill_cnt,
  output logic                        window_full,
  output logic                        overrun,
  output logic                        cfg_err
);

  typedef enum logic [1:0] {FILL, STEADY, ERR} state_t;

  state_t                  state;
  logic [LOG_WMAX-1:0]     W_q;
  logic                    in_valid_d;
  logic [LOG_WMAX-1:0]     med_idx;
  logic [DATA_LENGTH-1:0]  sel;
  logic                    flush;
  logic                    capture;

  assign cfg_err     = (W == '0) || (W > LOG_WMAX'(WMAX));
  assign flush       = (W != W_q);
  assign window_full = (state == STEADY) && (fill_cnt == W_q);

  // Cells are sorted descending, so 0-based index floor(W/2) is the (lower) median.
  assign med_idx = W_q >> 1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int k = 0; k < WMAX; k++) begin
      if (med_idx == LOG_WMAX'(k)) sel = R1_bus[k*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  always_comb begin
    capture = 1'b0;
    if (!flush && !cfg_err && in_valid_d) begin
      unique case (state)
        FILL:    capture = ((fill_cnt + LOG_WMAX'(1)) == W_q);
        STEADY:  capture = 1'b1;
        default: capture = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      W_q          <= '0;
      in_valid_d   <= 1'b0;
      fill_cnt     <= '0;
      median       <= '0;
      median_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      W_q        <= W;

      // A window-size change restarts the fill and swallows any sample this cycle.
      if (flush) begin
        fill_cnt <= '0;
        state    <= cfg_err ? ERR : FILL;
      end else if (cfg_err) begin
        fill_cnt <= '0;
        state    <= ERR;
      end else begin
        unique case (state)
          FILL: begin
            if (in_valid_d && (fill_cnt < W_q)) fill_cnt <= fill_cnt + LOG_WMAX'(1);
            if (capture) state <= STEADY;
          end
          STEADY: ;
          ERR: begin
            fill_cnt <= '0;
            state    <= FILL;
          end
          default: state <= FILL;
        endcase
      end

      if (capture) begin
        median       <= sel;
        median_valid <= 1'b1;
        if (median_valid && !out_ready) overrun <= 1'b1;
      end else if (median_valid && out_ready) begin
        median_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_out_stage.sv
// Directed bench for median_out_stage: emulates the array's sorted R1 bus and
// checks outputs against hand-computed medians.
module tb_median_out_stage;

  localparam int DL = 32;
  localparam int WM = 16;
  localparam int LW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [LW-1:0]    W;
  logic [WM*DL-1:0] R1_bus;
  logic             out_ready;
  logic [DL-1:0]    median;
  logic             median_valid;
  logic [LW-1:0]    fill_cnt;
  logic             window_full;
  logic             overrun;
  logic             cfg_err;

  int checks   = 0;
  int failures = 0;
  int cur_w    = 0;
  logic [DL-1:0] win[$];

  median_out_stage #(.DATA_LENGTH(DL), .WMAX(WM), .LOG_WMAX(LW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .W(W), .R1_bus(R1_bus),
    .out_ready(out_ready), .median(median), .median_valid(median_valid),
    .fill_cnt(fill_cnt), .window_full(window_full), .overrun(overrun),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one cycle of input; after the edge the array's R1 bus reflects the sample.
  task automatic step(input logic v, input logic [DL-1:0] x);
    logic [DL-1:0] s[$];
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      win.push_back(x);
      while (win.size() > cur_w) void'(win.pop_front());
      s = win;
      s.rsort();
      R1_bus = '0;
      for (int k = 0; k < s.size(); k++) R1_bus[k*DL +: DL] = s[k];
    end
    in_valid = 1'b0;
  endtask

  task automatic set_w(input int w);
    W     = LW'(w);
    cur_w = w;
    win.delete();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    R1_bus    = '0;
    set_w(3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_median", median, 0);
    check("rst_valid", median_valid, 0);
    check("rst_fill", fill_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_full", window_full, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0); step(0, 0);

    // W=3 fill: 5,9,1 -> median 5
    step(1, 5); step(1, 9);
    check("w3_not_yet", median_valid, 0);
    step(1, 1);
    check("w3_fill2", fill_cnt, 2);
    check("w3_lat1", median_valid, 0);
    step(0, 0);
    check("w3_valid", median_valid, 1);
    check("w3_median", median, 5);
    check("w3_fill", fill_cnt, 3);
    check("w3_full", window_full, 1);

    // slide with 7 -> window 9,1,7 -> median 7
    step(1, 7);
    check("w3_consumed", median_valid, 0);
    step(0, 0);
    check("w3b_valid", median_valid, 1);
    check("w3b_median", median, 7);
    check("w3b_overrun", overrun, 0);

    // W=4: 4,8,2,6 -> lower median 4
    set_w(4);
    step(0, 0);
    check("w4_flush_fill", fill_cnt, 0);
    check("w4_flush_full", window_full, 0);
    step(1, 4); step(1, 8); step(1, 2); step(1, 6);
    step(0, 0);
    check("w4_valid", median_valid, 1);
    check("w4_median", median, 4);
    check("w4_fill", fill_cnt, 4);
    step(0, 0);
    check("w4_consumed", median_valid, 0);

    // overrun: W=3, out_ready low for two results
    out_ready = 1'b0;
    set_w(3);
    step(0, 0);
    step(1, 10); step(1, 20); step(1, 30);
    step(0, 0);
    check("ovr_first", median, 20);
    check("ovr_first_flag", overrun, 0);
    step(1, 40);
    step(0, 0);
    check("ovr_second", median, 30);
    check("ovr_set", overrun, 1);
    out_ready = 1'b1;
    step(0, 0);
    check("ovr_drop_valid", median_valid, 0);
    check("ovr_hold_median", median, 30);
    check("ovr_sticky", overrun, 1);

    // W change 3->5 alongside in_valid_d; pending median retained
    out_ready = 1'b0;
    step(1, 50);
    step(0, 0);
    check("wc_pending", median, 40);
    step(1, 60);
    set_w(5);
    step(0, 0);
    check("wc_fill0", fill_cnt, 0);
    check("wc_kept_valid", median_valid, 1);
    check("wc_kept_median", median, 40);
    step(1, 3); step(1, 1); step(1, 4); step(1, 1); step(1, 5);
    check("wc_fill4", fill_cnt, 4);
    check("wc_no_capture", median, 40);
    out_ready = 1'b1;
    step(0, 0);
    check("w5_median", median, 3);
    check("w5_valid", median_valid, 1);
    check("w5_fill", fill_cnt, 5);

    // illegal W values
    set_w(0);
    #1;
    check("w0_cfg_err", cfg_err, 1);
    step(0, 0);
    check("w0_fill", fill_cnt, 0);
    check("w0_valid", median_valid, 0);
    step(1, 7); step(1, 8); step(0, 0);
    check("w0_no_capture", median_valid, 0);
    check("w0_fill_held", fill_cnt, 0);
    set_w(17);
    #1;
    check("w17_cfg_err", cfg_err, 1);
    step(1, 9); step(0, 0);
    check("w17_no_capture", median_valid, 0);
    check("w17_fill", fill_cnt, 0);
    set_w(3);
    step(0, 0);
    check("w3r_cfg_err", cfg_err, 0);
    step(1, 2); step(1, 7); step(1, 3);
    step(0, 0);
    check("w3r_median", median, 3);
    check("w3r_valid", median_valid, 1);
    check("w3r_full", window_full, 1);

    // asynchronous reset mid-cycle with a pending result
    out_ready = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("arst_median", median, 0);
    check("arst_valid", median_valid, 0);
    check("arst_fill", fill_cnt, 0);
    check("arst_full", window_full, 0);
    check("arst_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/median_out_stage.md
Name: median_out_stage

Overview:
- Downstream consumer of the median systolic cell array.
- Watches the sample stream entering the array and tracks how full the window is.
- Once the window holds W samples, picks the median cell's sorted register R1 off the array's R1 bus and presents it on a valid/ready output register.
- Detects window-size changes, overruns and illegal W.

Parameters:
- DATA_LENGTH, 32, width of one sample and of each cell's R1.
- WMAX, 16, number of cells in the array (maximum window).
- LOG_WMAX, 5, width of W and of the counters; must satisfy 2^LOG_WMAX > WMAX.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  X presented to the array this cycle (the array registers it at the next edge).
- W  in  LOG_WMAX  current window size, same signal the cells compare against cellNo.
- R1_bus  in  WMAX*DATA_LENGTH  concatenated R1 of all cells; cell k (1-based, k=1 largest) at bits [(k-1)*DATA_LENGTH +: DATA_LENGTH].
- out_ready  in  1  downstream accepts median this cycle.
- median  out  DATA_LENGTH  selected median sample.
- median_valid  out  1  median holds an unconsumed result.
- fill_cnt  out  LOG_WMAX  samples currently in window, saturates at W.
- window_full  out  1  fill_cnt == W and W legal.
- overrun  out  1  sticky: an unconsumed result was overwritten.
- cfg_err  out  1  W == 0 or W > WMAX (combinational from W).

Behaviour:
- Reset (reset=0, async): median=0, median_valid=0, fill_cnt=0, overrun=0, internal W_q=0, in_valid_d=0, state=FILL. Release is synchronous to clk (two-flop sync not inside this block).
- in_valid_d is a registered copy of in_valid. R1_bus reflects sample n in the cycle where in_valid_d=1 for that sample. All capture decisions use in_valid_d.
- Median index: m = floor(W_q/2)+1.
  - Odd W gives the true median.
  - Even W gives the lower median, since cells are in descending order.
  - Selection is a WMAX:1 mux on R1_bus, combinational into the capture register.
- States:
  - FILL: on in_valid_d, fill_cnt++. When fill_cnt reaches W_q on that sample, capture and go to STEADY.
  - STEADY: every in_valid_d captures; fill_cnt stays at W_q.
  - ERR: entered while cfg_err=1. No captures, fill_cnt held at 0. Leaves to FILL when W becomes legal.
- Capture: median <= selected cell, median_valid <= 1, one cycle after the in_valid_d cycle.
  - Latency from in_valid of the completing sample to median_valid = 2 clocks.
- Handshake:
  - median_valid && out_ready clears median_valid at the edge, unless a capture occurs in the same cycle. In that case the new value loads and median_valid stays 1, with no overrun.
  - Capture while median_valid && !out_ready: new value overwrites and overrun is set. overrun stays set until reset.
  - median is stable while median_valid=1 and not overwritten.
- W change: W is sampled into W_q every clock. If W != W_q, flush: fill_cnt <= 0 and state <= FILL (or ERR if illegal).
  - Flush takes priority over a simultaneous in_valid_d; that sample is not counted.
  - A pending median_valid is kept.
  - The array itself is flushed by the system reset path, not here.
- fill_cnt width rules: compare with zero-extended W_q. No wrap: the increment is gated at W_q.
- window_full is registered-state derived (fill_cnt==W_q && state==STEADY).
- Reset asserted mid-stream clears everything immediately, including a pending median.

Test Plan:
- W=3, reset released, samples 5,9,1 on consecutive cycles, out_ready=1 -> median_valid first high 2 clocks after the sample "1" in_valid, median=5 (cell 2 of 9,5,1). fill_cnt=3, window_full=1.
- Continue W=3 with sample 7 (window 9,1,7 sorted 9,7,1) -> median=7 one result per sample, overrun=0.
- W=4, samples 4,8,2,6 -> median=4 (cell 3 of 8,6,4,2, lower median).
- W=3 steady stream with out_ready=0 for two results -> second result overwrites, overrun=1 sticky. Then out_ready=1 -> median_valid drops next edge with no new capture.
- W changes 3->5 mid-stream alongside in_valid_d -> fill_cnt=0 that edge, sample not counted. No capture until 5 further samples; pending median retained.
- W=0 then W=17 -> cfg_err=1, no median_valid, fill_cnt=0. Then W=3 -> normal fill resumes. Assert reset=0 with median_valid=1 -> all outputs zero asynchronously.
